// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_m master channel between N_REQ requesters.
// Grants one requester, launches the master via newd/din, and returns the received byte on done.
module spi_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic [7:0]         rsp_data,
    output logic               busy,
    output logic               m_newd,
    output logic [7:0]         m_din,
    input  logic               m_cs,
    input  logic [7:0]         m_dout
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, XFER, DONE} state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] win;
    logic [IW-1:0] pick;
    logic          found;
    logic          cs_q;
    logic [7:0]    shadow;
    logic [CW-1:0] cnt;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = last;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last) + i) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            rsp_data <= 8'h00;
            busy     <= 1'b0;
            m_newd   <= 1'b0;
            m_din    <= 8'h00;
            last     <= IW'(N_REQ - 1);
            win      <= '0;
            cs_q     <= 1'b1;
            shadow   <= 8'h00;
            cnt      <= '0;
        end else begin
            // cs_q keeps tracking in IDLE so a transfer orphaned by reset cannot pose as a fresh launch.
            cs_q     <= m_cs;
            done     <= '0;
            err      <= 1'b0;
            rsp_data <= 8'h00;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt    <= N_REQ'(1) << pick;
                        win    <= pick;
                        m_din  <= req_data[int'(pick)*8 +: 8];
                        shadow <= 8'h00;
                        cnt    <= '0;
                        m_newd <= 1'b1;
                        busy   <= 1'b1;
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (cs_q && !m_cs) begin
                        m_newd <= 1'b0;
                        state  <= XFER;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        m_newd <= 1'b0;
                        done   <= gnt;
                        err    <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (!cs_q && m_cs) begin
                        done     <= gnt;
                        rsp_data <= (m_dout != 8'h00) ? m_dout : shadow;
                        state    <= DONE;
                    end else if (m_dout != 8'h00) begin
                        shadow <= m_dout;
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    last  <= win;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
